// File: rtl/trap_controller_if.sv
// Request/CSR/redirect bundle between the execute stage and the user-mode trap controller.
// The slave modport is the controller; the master modport is the pipeline side.
interface trap_controller_if #(
  parameter int CSR_ADDR_W = 7
);
  logic [5:0]            iException;
  logic [2:0]            iIntPending;
  logic                  iURET;
  logic [31:0]           iPC;
  logic [31:0]           iUSTATUS;
  logic [31:0]           iUIE;
  logic [31:0]           iUTVEC;
  logic [31:0]           iUEPC;

  logic                  oUCAUSEWrite;
  logic [31:0]           oUCAUSEData;
  logic                  oUEPCWrite;
  logic [31:0]           oUEPCData;
  logic                  oCSRWrite;
  logic [CSR_ADDR_W-1:0] oCSRAddr;
  logic [31:0]           oCSRData;
  logic                  oPCLoad;
  logic [31:0]           oPCTarget;
  logic                  oStall;

  modport slave (
    input  iException, iIntPending, iURET, iPC, iUSTATUS, iUIE, iUTVEC, iUEPC,
    output oUCAUSEWrite, oUCAUSEData, oUEPCWrite, oUEPCData,
           oCSRWrite, oCSRAddr, oCSRData, oPCLoad, oPCTarget, oStall
  );

  modport master (
    output iException, iIntPending, iURET, iPC, iUSTATUS, iUIE, iUTVEC, iUEPC,
    input  oUCAUSEWrite, oUCAUSEData, oUEPCWrite, oUEPCData,
           oCSRWrite, oCSRAddr, oCSRData, oPCLoad, oPCTarget, oStall
  );
endinterface

// File: rtl/trap_controller.sv
// User-mode trap controller: takes exceptions, uret and enabled interrupts, writes
// ucause/uepc/ustatus and redirects fetch.
//
// state   | meaning
// IDLE    | waiting; a request is accepted combinationally (stall raised this cycle)
// SAVE    | write ucause, uepc and ustatus (UPIE<=UIE, UIE<=0)
// RESTORE | write ustatus (UIE<=UPIE, UPIE<=1), capture uepc as return target
// JUMP    | redirect fetch to trap vector or saved uepc
module trap_controller #(
  parameter bit VECTORED_EN = 1'b1,
  parameter int CSR_ADDR_W  = 7
) (
  input logic              iCLK,
  input logic              iRST,
  trap_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    JUMP    = 2'd3
  } state_t;

  localparam logic [CSR_ADDR_W-1:0] USTATUS_IDX = '0;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ustatus_q, ustatus_d;
  logic [31:0] uepc_q, uepc_d;
  logic        intr_q, intr_d;
  logic        uret_q, uret_d;

  logic        exc_any;
  logic [2:0]  int_hits;
  logic        int_any;
  logic        accept;
  logic [31:0] exc_cause;
  logic [31:0] int_cause;
  logic [31:0] trap_target;

  logic                  ucause_we;
  logic [31:0]           ucause_data;
  logic                  uepc_we;
  logic [31:0]           uepc_data;
  logic                  csr_we;
  logic [CSR_ADDR_W-1:0] csr_addr;
  logic [31:0]           csr_data;
  logic                  pc_load;
  logic [31:0]           pc_target;
  logic                  stall;

  logic unused_uie;
  assign unused_uie = ^{bus.iUIE[31:9], bus.iUIE[7:5], bus.iUIE[3:1]};

  assign exc_any  = |bus.iException;
  assign int_hits = bus.iIntPending & {bus.iUIE[8], bus.iUIE[4], bus.iUIE[0]}
                    & {3{bus.iUSTATUS[0]}};
  assign int_any  = |int_hits;
  // Held reset suppresses accept so every output reads zero while iRST is low.
  assign accept   = iRST && (state_q == IDLE) && (exc_any || bus.iURET || int_any);

  // Exceptions ranked by cause code, so ecall (8) loses to load/store misaligned (4, 6).
  always_comb begin
    exc_cause = 32'd0;
    if (bus.iException[0])      exc_cause = 32'd0;
    else if (bus.iException[1]) exc_cause = 32'd2;
    else if (bus.iException[2]) exc_cause = 32'd3;
    else if (bus.iException[4]) exc_cause = 32'd4;
    else if (bus.iException[5]) exc_cause = 32'd6;
    else if (bus.iException[3]) exc_cause = 32'd8;
  end

  always_comb begin
    int_cause = 32'h8000_0004;
    if (int_hits[2])      int_cause = 32'h8000_0008;
    else if (int_hits[0]) int_cause = 32'h8000_0000;
  end

  always_comb begin
    trap_target = {bus.iUTVEC[31:2], 2'b00};
    if (VECTORED_EN && (bus.iUTVEC[1:0] == 2'b01) && intr_q) begin
      trap_target = {bus.iUTVEC[31:2], 2'b00} + {25'd0, cause_q[4:0], 2'b00};
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    ustatus_d = ustatus_q;
    uepc_d    = uepc_q;
    intr_d    = intr_q;
    uret_d    = uret_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (exc_any) begin
            cause_d   = exc_cause;
            pc_d      = bus.iPC;
            ustatus_d = bus.iUSTATUS;
            intr_d    = 1'b0;
            uret_d    = 1'b0;
            state_d   = SAVE;
          end else if (bus.iURET) begin
            uret_d  = 1'b1;
            intr_d  = 1'b0;
            state_d = RESTORE;
          end else begin
            cause_d   = int_cause;
            pc_d      = bus.iPC;
            ustatus_d = bus.iUSTATUS;
            intr_d    = 1'b1;
            uret_d    = 1'b0;
            state_d   = SAVE;
          end
        end
      end
      SAVE: state_d = JUMP;
      RESTORE: begin
        uepc_d  = bus.iUEPC;
        state_d = JUMP;
      end
      JUMP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      ustatus_q <= '0;
      uepc_q    <= '0;
      intr_q    <= 1'b0;
      uret_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      ustatus_q <= ustatus_d;
      uepc_q    <= uepc_d;
      intr_q    <= intr_d;
      uret_q    <= uret_d;
    end
  end

  // The CSR file adds 4 on a uepc write, hence PC-4 for interrupts to resume in place.
  always_comb begin
    ucause_we   = 1'b0;
    ucause_data = '0;
    uepc_we     = 1'b0;
    uepc_data   = '0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_data    = '0;
    pc_load     = 1'b0;
    pc_target   = '0;
    case (state_q)
      SAVE: begin
        ucause_we   = 1'b1;
        ucause_data = cause_q;
        uepc_we     = 1'b1;
        uepc_data   = intr_q ? (pc_q - 32'd4) : pc_q;
        csr_we      = 1'b1;
        csr_addr    = USTATUS_IDX;
        csr_data    = {ustatus_q[31:5], ustatus_q[0], ustatus_q[3:1], 1'b0};
      end
      RESTORE: begin
        csr_we   = 1'b1;
        csr_addr = USTATUS_IDX;
        csr_data = {bus.iUSTATUS[31:5], 1'b1, bus.iUSTATUS[3:1], bus.iUSTATUS[4]};
      end
      JUMP: begin
        pc_load   = 1'b1;
        pc_target = uret_q ? uepc_q : trap_target;
      end
      default: ;
    endcase
  end

  assign stall = accept || (state_q != IDLE);

  assign bus.oUCAUSEWrite = ucause_we;
  assign bus.oUCAUSEData  = ucause_data;
  assign bus.oUEPCWrite   = uepc_we;
  assign bus.oUEPCData    = uepc_data;
  assign bus.oCSRWrite    = csr_we;
  assign bus.oCSRAddr     = csr_addr;
  assign bus.oCSRData     = csr_data;
  assign bus.oPCLoad      = pc_load;
  assign bus.oPCTarget    = pc_target;
  assign bus.oStall       = stall;

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter VECTORED_EN, default 1, meaning utvec MODE=1 vectoring is honoured for interrupts (0: always direct).
REQ-002 SHALL have parameter CSR_ADDR_W, default 7, meaning width of the CSR index driven on oCSRAddr.
REQ-003 iCLK  in  1  system clock; single clock domain; all state updates on rising edge.
REQ-004 iRST  in  1  reset; synchronous, active-low.
REQ-005 iException  in  6  one-hot-or-more exception requests: [0] instr misaligned, [1] illegal instr, [2] ebreak, [3] ecall, [4] load misaligned, [5] store misaligned.
REQ-006 iIntPending  in  3  level interrupt requests: [0] software, [1] timer, [2] external.
REQ-007 iURET  in  1  uret instruction in execute.
REQ-008 iPC  in  32  address of instruction in execute.
REQ-009 iUSTATUS, iUIE, iUTVEC, iUEPC  in  32 each  current CSR values (indices 0, 4, 5, 65).
REQ-010 oUCAUSEWrite, oUEPCWrite  out  1  dedicated-port write strobes to the CSR register file.
REQ-011 oUCAUSEData, oUEPCData  out  32  dedicated-port write data.
REQ-012 oCSRWrite  out  1; oCSRAddr  out  CSR_ADDR_W; oCSRData  out  32  generic-port write of ustatus.
REQ-013 oPCLoad  out  1; oPCTarget  out  32  PC redirect to the fetch stage.
REQ-014 oStall  out  1  datapath hold; pipeline SHALL issue no CSR writes while high.

Function
REQ-015 FSM states SHALL be IDLE, SAVE, RESTORE, JUMP.
REQ-016 In IDLE, accept SHALL occur when any iException bit is set, else when iURET=1, else when an interrupt is enabled (iUSTATUS[0]=1 and matching iUIE bit: software->bit0, timer->bit4, external->bit8).
REQ-017 Priority SHALL be: exception > uret > interrupt; exceptions by lowest-numbered cause code; interrupts external > software > timer.
REQ-018 Exception codes SHALL be 0,2,3,8,4,6 for iException[0..5]; interrupt codes 0,4,8 for software/timer/external with bit31 of cause set.
REQ-019 On trap accept SHALL latch cause, iPC, interrupt flag; next state SAVE. On uret accept next state RESTORE.
REQ-020 SAVE (1 cycle): oUCAUSEWrite=1 with latched cause; oUEPCWrite=1; oCSRWrite=1, oCSRAddr=0, oCSRData = latched ustatus with bit4(UPIE)<=bit0(UIE), bit0<=0; next JUMP.
REQ-021 CSR register file adds 4 on UEPC write; oUEPCData SHALL be latched PC for exceptions (resume after) and latched PC-4 for interrupts (resume at interrupted instruction), 32-bit wrap-around.
REQ-022 RESTORE (1 cycle): oCSRWrite=1, addr 0, data = iUSTATUS with bit0<=bit4, bit4<=1; next JUMP with target iUEPC.
REQ-023 JUMP (1 cycle): oPCLoad=1; trap target = {iUTVEC[31:2],2'b00} + (VECTORED_EN and iUTVEC[1:0]=1 and interrupt ? 4*code : 0); uret target = iUEPC sampled in RESTORE; next IDLE.
REQ-024 oStall SHALL be 1 in the accept cycle (combinational) and in SAVE, RESTORE, JUMP; 0 otherwise.
REQ-025 Requests arriving while not IDLE SHALL be ignored; interrupts are level and re-evaluated in IDLE.
REQ-026 All strobes SHALL be 0 in states not listed above; data outputs SHALL be 0 when strobe is 0.
REQ-027 Throughput: trap occupies exactly 3 cycles (accept, SAVE, JUMP); back-to-back trap possible in cycle after JUMP.

Reset
REQ-028 iRST=0 at a rising edge SHALL force IDLE, clear latches, and drive all outputs 0 in the following cycle, including mid-SAVE/RESTORE/JUMP; no partial write completes after reset.

Verification
REQ-029 ecall: iException=6'b001000, iPC=0x400010, iUSTATUS=1, iUTVEC=0x400100 -> SAVE: cause=8, oUEPCData=0x400010, ustatus data=0x10; JUMP: oPCTarget=0x400100.
REQ-030 Vectored timer interrupt: iUSTATUS=1, iUIE=0x10, iIntPending=3'b010, iUTVEC=0x400101, iPC=0x400020 -> cause=0x80000004, oUEPCData=0x40001C, target=0x400110.
REQ-031 Simultaneous illegal instr + ebreak + external interrupt (enabled) -> cause=2, interrupt ignored, direct target.
REQ-032 uret: iURET=1, iUSTATUS=0x10, iUEPC=0x400014 -> RESTORE ustatus data=0x11; JUMP target=0x400014; oStall high 3 cycles.
REQ-033 Interrupt masked (iUSTATUS[0]=0, iIntPending=3'b111) -> no accept, oStall=0 for 10 cycles.
REQ-034 iRST=0 asserted during SAVE -> next cycle all strobes 0, state IDLE; pending ecall re-accepted after release.
